adc_packetizer_64: RTL and testbench

Parametrised successor to the 64-bit ADC stream producer. It captures one multi-channel ADC sample per `new_sample` strobe and packs the channels into 64-bit AXI4-Stream words. Each packet starts with a header word carrying a sequence number and drop statistics, and ends with `tlast`. The block sits in the `data_clk` domain ahead of the clock-crossing AXI-stream FIFO that feeds the XDMA C2H channel. It adds a test-pattern mode and sample-overrun accounting.

---
 rtl/adc_packetizer_64.sv | 205 ++++++++++++++++++++
 tb/tb_adc_packetizer_64.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_packetizer_64.sv
// Packs one multi-channel ADC sample per new_sample strobe into 64-bit AXI4-Stream words,
// framing each packet with a header word (sequence number, drop statistics) and tlast.
module adc_packetizer_64 #(
  parameter int N_CHAN          = 16,
  parameter int SAMPLES_PER_PKT = 32,
  parameter int SEQ_WIDTH       = 16
) (
  input  logic                  data_clk,
  input  logic                  dma_rstn,
  input  logic                  dma_ena,
  input  logic                  test_mode,
  input  logic                  new_sample,
  input  logic [N_CHAN*16-1:0]  adc_data,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           pkt_count,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int         WPS         = N_CHAN / 4;
  localparam int         CAP_W       = N_CHAN * 16;
  localparam logic [3:0]  LAST_WORD   = 4'(WPS - 1);
  localparam logic [11:0] LAST_SAMPLE = 12'(SAMPLES_PER_PKT - 1);

  typedef enum logic [1:0] {IDLE, HEADER, WAIT_SAMPLE, DATA} state_t;

  function automatic logic [63:0] word_of(input logic [CAP_W-1:0] cap, input logic [3:0] w);
    return cap[int'(w)*64 +: 64];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [14:0] sat_inc15(input logic [14:0] v);
    return (v == 15'h7FFF) ? v : v + 15'd1;
  endfunction

  state_t                 state_q, state_d;
  logic [11:0]            sidx_q, sidx_d;
  logic [3:0]             widx_q, widx_d;
  logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
  logic                   ovf_q, ovf_d;
  logic [14:0]            drops_pkt_q, drops_pkt_d;
  logic [15:0]            drop_count_q, drop_count_d;
  logic [31:0]            pkt_count_q, pkt_count_d;
  logic [63:0]            tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic [CAP_W-1:0]       cap_q, cap_d;
  logic [CAP_W-1:0]       pattern;
  logic                   hs, drop, last_sample;
  logic [3:0]             widx_nxt;

  always_comb begin
    pattern = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      pattern[c*16 +: 16] = {sidx_q[9:0], 6'(c)};
    end
  end

  assign hs          = tvalid_q & m_axis_tready;
  assign drop        = new_sample & ((state_q == HEADER) | (state_q == DATA));
  assign last_sample = (sidx_q == LAST_SAMPLE);
  assign widx_nxt    = widx_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    sidx_d       = sidx_q;
    widx_d       = widx_q;
    seq_d        = seq_q;
    ovf_d        = ovf_q;
    drops_pkt_d  = drops_pkt_q;
    drop_count_d = drop_count_q;
    pkt_count_d  = pkt_count_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    cap_d        = cap_q;

    if (drop) begin
      drop_count_d = sat_inc16(drop_count_q);
      drops_pkt_d  = sat_inc15(drops_pkt_q);
      ovf_d        = 1'b1;
    end

    case (state_q)
      IDLE: begin
        sidx_d      = '0;
        widx_d      = '0;
        seq_d       = '0;
        ovf_d       = 1'b0;
        drops_pkt_d = '0;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        if (dma_ena) state_d = HEADER;
      end
      HEADER: begin
        // First HEADER cycle loads the word; it is then held until accepted.
        if (!tvalid_q) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = {16'hADC0, 16'(seq_q), ovf_q, drops_pkt_q, 16'(SAMPLES_PER_PKT)};
        end else if (hs) begin
          tvalid_d    = 1'b0;
          ovf_d       = drop;
          drops_pkt_d = drop ? 15'd1 : 15'd0;
          state_d     = WAIT_SAMPLE;
        end
      end
      WAIT_SAMPLE: begin
        tvalid_d = 1'b0;
        if (new_sample) begin
          cap_d    = test_mode ? pattern : adc_data;
          widx_d   = '0;
          tvalid_d = 1'b1;
          tdata_d  = word_of(cap_d, 4'd0);
          tlast_d  = (LAST_WORD == 4'd0) && last_sample;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (hs) begin
          if (widx_q == LAST_WORD) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (last_sample) begin
              seq_d       = seq_q + SEQ_WIDTH'(1);
              sidx_d      = '0;
              pkt_count_d = pkt_count_q + 32'd1;
              state_d     = HEADER;
            end else begin
              sidx_d  = sidx_q + 12'd1;
              state_d = WAIT_SAMPLE;
            end
          end else begin
            widx_d  = widx_nxt;
            tdata_d = word_of(cap_q, widx_nxt);
            tlast_d = (widx_nxt == LAST_WORD) && last_sample;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!dma_ena) begin
      state_d      = IDLE;
      tvalid_d     = 1'b0;
      tlast_d      = 1'b0;
      drop_count_d = '0;
      pkt_count_d  = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge data_clk or negedge dma_rstn) begin
    if (!dma_rstn) begin
      state_q      <= IDLE;
      sidx_q       <= '0;
      widx_q       <= '0;
      seq_q        <= '0;
      ovf_q        <= 1'b0;
      drops_pkt_q  <= '0;
      drop_count_q <= '0;
      pkt_count_q  <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sidx_q       <= sidx_d;
      widx_q       <= widx_d;
      seq_q        <= seq_d;
      ovf_q        <= ovf_d;
      drops_pkt_q  <= drops_pkt_d;
      drop_count_q <= drop_count_d;
      pkt_count_q  <= pkt_count_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
    end
  end

  // Capture register is pure data and needs no reset.
  always_ff @(posedge data_clk) begin
    cap_q <= cap_d;
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = 8'hFF;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_count     = pkt_count_q;
  assign drop_count    = drop_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_adc_packetizer_64.sv
// Bench for adc_packetizer_64: packet-level reference model fed with random and
// test-pattern samples, random back-pressure, overrun, abort and async reset steps.
module tb_adc_packetizer_64;

  localparam int N_CHAN = 16;
  localparam int SPP    = 2;
  localparam int SEQW   = 2;
  localparam int WPS    = N_CHAN / 4;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  dma_ena;
  logic                  test_mode;
  logic                  new_sample;
  logic [N_CHAN*16-1:0]  adc_data;
  logic [63:0]           tdata;
  logic [7:0]            tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [31:0]           pkt_count;
  logic [15:0]           drop_count;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;
  bit bp    = 1'b0;

  logic [64:0] rx_q[$];
  logic [64:0] exp_q[$];

  logic        prv_stall = 1'b0;
  logic        prv_ena   = 1'b0;
  logic        prv_rstn  = 1'b0;
  logic [63:0] prv_data  = '0;
  logic        prv_last  = 1'b0;

  adc_packetizer_64 #(.N_CHAN(N_CHAN), .SAMPLES_PER_PKT(SPP), .SEQ_WIDTH(SEQW)) dut (
    .data_clk      (clk),
    .dma_rstn      (rstn),
    .dma_ena       (dma_ena),
    .test_mode     (test_mode),
    .new_sample    (new_sample),
    .adc_data      (adc_data),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Collect accepted words and check that a stalled word is held.
  always @(negedge clk) begin
    if (rstn && tvalid && tready) rx_q.push_back({tlast, tdata});
    if (rstn && prv_rstn && prv_stall && prv_ena) begin
      n_vec++;
      assert (tvalid === 1'b1 && tdata === prv_data && tlast === prv_last)
        else begin
          n_err++;
          $error("FAIL stall_hold observed v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                 tvalid, tdata, tlast, prv_data, prv_last);
        end
    end
    prv_stall <= tvalid && !tready;
    prv_ena   <= dma_ena;
    prv_rstn  <= rstn;
    prv_data  <= tdata;
    prv_last  <= tlast;
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rx(input int n);
    int b = 0;
    while (rx_q.size() < n && b < 400) begin
      step();
      b++;
    end
    n_vec++;
    assert (rx_q.size() >= n)
      else begin
        n_err++;
        $error("FAIL rx_timeout observed=%0d words expected=%0d", rx_q.size(), n);
      end
  endtask

  function automatic logic [64:0] hdr(input int seq, input bit ovf, input int drops);
    return {1'b0, 16'hADC0, 16'(seq % (1 << SEQW)), ovf, 15'(drops), 16'(SPP)};
  endfunction

  // Drive one sample strobe and append its expected words to the model queue.
  task automatic strobe(input bit tm, input int s);
    logic [15:0] vals [N_CHAN];
    logic [63:0] wd;
    for (int c = 0; c < N_CHAN; c++) begin
      vals[c] = tm ? 16'(s * 64 + c) : 16'($urandom);
      adc_data[c*16 +: 16] = tm ? 16'($urandom) : vals[c];
    end
    test_mode  = tm;
    new_sample = 1'b1;
    step();
    new_sample = 1'b0;
    test_mode  = ~tm;
    adc_data   = {N_CHAN{16'($urandom)}};
    for (int w = 0; w < WPS; w++) begin
      for (int k = 0; k < 4; k++) wd[k*16 +: 16] = vals[4*w + k];
      exp_q.push_back({(s == SPP - 1) && (w == WPS - 1), wd});
    end
  endtask

  task automatic do_packet(input int seq, input bit ovf, input int drops, input bit tm,
                           input bit ovr, input string tag);
    exp_q.push_back(hdr(seq, ovf, drops));
    wait_rx(1);
    for (int s = 0; s < SPP; s++) begin
      if (ovr && s == 0) tready = 1'b0;
      strobe(tm, s);
      if (ovr && s == 0) begin
        for (int k = 0; k < 3; k++) begin
          new_sample = 1'b1;
          step();
          new_sample = 1'b0;
          step();
        end
        check({tag, "_drop_count"}, 65'(drop_count), 65'd3);
        check({tag, "_stalled_word"}, {tvalid, tdata}, {1'b1, exp_q[1][63:0]});
        tready = 1'b1;
      end
      wait_rx(1 + (s + 1) * WPS);
    end
    check({tag, "_word_count"}, 65'(rx_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rstn       = 1'b0;
    dma_ena    = 1'b0;
    test_mode  = 1'b0;
    new_sample = 1'b0;
    adc_data   = '0;
    tready     = 1'b1;
    repeat (3) step();
    check("rst_tvalid", 65'(tvalid), 65'd0);
    check("rst_tlast", 65'(tlast), 65'd0);
    check("rst_tdata", 65'(tdata), 65'd0);
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_pkt_count", 65'(pkt_count), 65'd0);
    check("rst_drop_count", 65'(drop_count), 65'd0);
    check("tkeep", 65'(tkeep), 65'hFF);
    rstn = 1'b1;
    step();

    // Strobes while idle are ignored.
    new_sample = 1'b1;
    step();
    new_sample = 1'b0;
    step();
    check("idle_no_drop", 65'(drop_count), 65'd0);
    check("idle_busy", 65'(busy), 65'd0);

    // Enable: HEADER state after one edge, header valid after the second.
    dma_ena = 1'b1;
    step();
    check("ena_t1_tvalid", 65'(tvalid), 65'd0);
    check("ena_t1_busy", 65'(busy), 65'd1);
    step();
    check("ena_t2_header", {tvalid, tdata}, {1'b1, 64'hADC0_0000_0000_0002});

    do_packet(0, 1'b0, 0, 1'b1, 1'b0, "basic");
    check("basic_pkt_count", 65'(pkt_count), 65'd1);

    bp = 1'b1;
    for (int p = 1; p < 5; p++) begin
      do_packet(p, 1'b0, 0, 1'($urandom_range(0, 1)), 1'b0, $sformatf("bp_pkt%0d", p));
    end
    bp = 1'b0;
    tready = 1'b1;
    check("wrap_pkt_count", 65'(pkt_count), 65'd5);

    do_packet(5, 1'b0, 0, 1'b0, 1'b1, "ovr");
    do_packet(6, 1'b1, 3, 1'b0, 1'b0, "ovr_hdr");
    do_packet(7, 1'b0, 0, 1'b1, 1'b0, "ovr_clear");
    do_packet(8, 1'b0, 0, 1'b0, 1'b0, "pre_abort");
    check("pre_abort_pkt_count", 65'(pkt_count), 65'd9);

    // Abort in the middle of a stalled data word of packet seq 1.
    wait_rx(1);
    tready = 1'b0;
    strobe(1'b0, 0);
    check("abort_pre_tvalid", 65'(tvalid), 65'd1);
    dma_ena = 1'b0;
    step();
    check("abort_tvalid", 65'(tvalid), 65'd0);
    check("abort_busy", 65'(busy), 65'd0);
    check("abort_pkt_count", 65'(pkt_count), 65'd0);
    check("abort_drop_count", 65'(drop_count), 65'd0);
    rx_q.delete();
    exp_q.delete();
    tready  = 1'b1;
    dma_ena = 1'b1;
    do_packet(0, 1'b0, 0, 1'b1, 1'b0, "reena");
    check("reena_pkt_count", 65'(pkt_count), 65'd1);

    // Async reset while a header is being presented.
    tready = 1'b0;
    begin
      int b = 0;
      while (!tvalid && b < 50) begin
        step();
        b++;
      end
    end
    check("areset_pre_tvalid", 65'(tvalid), 65'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("areset_tvalid", 65'(tvalid), 65'd0);
    check("areset_busy", 65'(busy), 65'd0);
    check("areset_pkt_count", 65'(pkt_count), 65'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
